spi_peripheral: RTL and testbench

SPI responder (mode 0: DCLK idles low, sample on rising, shift on falling) for the far end of our `spi_con` controller link, e.g. an FPGA-side test target or inter-board link. Samples the asynchronous CS/DCLK/COPI pins into the system clock domain and deserializes COPI into received words. Serializes a host-supplied response word onto CIPO in the same transaction. Supports back-to-back words within one CS-low frame and flags aborted frames.

---
 rtl/spi_peripheral.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_peripheral.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// -----------------------------------------------------------------------------
// spi_peripheral
//   SPI mode-0 responder. DCLK idles low. COPI is sampled on the rising edge and
//   CIPO is shifted on the falling edge. The asynchronous CS/DCLK/COPI pins are
//   synchronised into clk_in. Received words are deserialised MSB first. A
//   host-supplied response word is serialised onto CIPO in the same
//   transaction. Several words may be sent back to back while CS stays low.
//   A frame that ends in the middle of a word is flagged as an error.
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous active-low reset
//   chip_sel_in     CS from the controller, active low, asynchronous
//   chip_clk_in     DCLK from the controller, asynchronous
//   chip_data_in    COPI, asynchronous
//   chip_data_out   CIPO, 0 whenever no frame is active
//   tx_data_in      next response word
//   tx_load_in      capture tx_data_in into the single-entry TX buffer
//   tx_ready_out    TX buffer empty, so a load will be accepted
//   rx_data_out     last received word, held until the next one arrives
//   rx_valid_out    one-cycle pulse: rx_data_out was updated
//   tx_underrun_out one-cycle pulse: a word started with the TX buffer empty
//   frame_error_out one-cycle pulse: CS rose in the middle of a word
// -----------------------------------------------------------------------------
module spi_peripheral #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  chip_sel_in,
  input  logic                  chip_clk_in,
  input  logic                  chip_data_in,
  output logic                  chip_data_out,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_load_in,
  output logic                  tx_ready_out,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid_out,
  output logic                  tx_underrun_out,
  output logic                  frame_error_out
);

  localparam int CNT_W   = $clog2(DATA_WIDTH + 1);
  localparam int FLUSH   = SYNC_STAGES + 1;
  localparam int FLUSH_W = $clog2(FLUSH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Pin synchronisers. Bit 0 is the flop closest to the pin.
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] dclk_sync_q, dclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic                   cs_hist_q,   cs_hist_d;
  logic                   dclk_hist_q, dclk_hist_d;

  logic [FLUSH_W-1:0]    flush_q,     flush_d;
  state_e                state_q,     state_d;
  logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q,  rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q,  tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q,    tx_buf_d;
  logic                  tx_full_q,   tx_full_d;
  logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
  logic                  rx_valid_q,  rx_valid_d;
  logic                  underrun_q,  underrun_d;
  logic                  frame_err_q, frame_err_d;

  logic                  cs_s, dclk_s, copi_s;
  logic                  settled;
  logic                  cs_fall, cs_rise, dclk_rise, dclk_fall;
  logic                  start_word;
  logic [DATA_WIDTH-1:0] rx_word;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign dclk_s = dclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  // The CS chain comes out of reset reading "high". If the pin is actually low
  // when reset is released, flushing the chain would look like a CS fall and
  // open a frame in the middle of a transfer. CS edges are therefore ignored
  // until the chain has been refilled from the pin. After that, a low CS only
  // opens a frame once it has been seen high and then falls again.
  assign settled   = (flush_q == FLUSH_W'(FLUSH));
  assign cs_fall   = settled &  cs_hist_q   & ~cs_s;
  assign cs_rise   = settled & ~cs_hist_q   &  cs_s;
  assign dclk_rise =           ~dclk_hist_q &  dclk_s;
  assign dclk_fall =            dclk_hist_q & ~dclk_s;

  assign rx_word = {rx_shift_q[DATA_WIDTH-2:0], copi_s};

  // NOTE: every signal assigned in this block gets a default value first.
  // An output that is left unassigned on some path would infer a latch.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   chip_sel_in};
    dclk_sync_d = {dclk_sync_q[SYNC_STAGES-2:0], chip_clk_in};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], chip_data_in};
    cs_hist_d   = cs_s;
    dclk_hist_d = dclk_s;
    flush_d     = settled ? flush_q : flush_q + FLUSH_W'(1);

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    start_word  = 1'b0;

    case (state_q)
      IDLE: begin
        // DCLK edges seen while idle are ignored.
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          start_word = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // A partial word is dropped. Whatever was in the TX shifter is lost.
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
        end else if (dclk_rise) begin
          rx_shift_d = rx_word;
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
        end else if (dclk_fall) begin
          // A count of zero means the previous word has just completed, so
          // this falling edge presents the first bit of the next word.
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end else begin
            start_word = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The word start reads the buffer state before any load in the same
    // cycle. A load that coincides with an empty-buffer start still underruns,
    // and the loaded word is kept for the next word.
    if (start_word) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end
    if (tx_load_in && !tx_full_q) begin
      tx_buf_d  = tx_data_in;
      tx_full_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples its _d value from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cs_sync_q   <= '1;
      dclk_sync_q <= '0;
      copi_sync_q <= '0;
      cs_hist_q   <= 1'b1;
      dclk_hist_q <= 1'b0;
      flush_q     <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      dclk_sync_q <= dclk_sync_d;
      copi_sync_q <= copi_sync_d;
      cs_hist_q   <= cs_hist_d;
      dclk_hist_q <= dclk_hist_d;
      flush_q     <= flush_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign chip_data_out   = (state_q == ACTIVE) & tx_shift_q[DATA_WIDTH-1];
  assign tx_ready_out    = ~tx_full_q;
  assign rx_data_out     = rx_data_q;
  assign rx_valid_out    = rx_valid_q;
  assign tx_underrun_out = underrun_q;
  assign frame_error_out = frame_err_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// -----------------------------------------------------------------------------
// tb_spi_peripheral
//   Bench for spi_peripheral. A behavioural mode-0 SPI controller drives the
//   pins. A reference model of the single-entry TX buffer predicts each CIPO
//   word and the underrun pulses. Expected RX words go into a queue, and an
//   independent monitor pops that queue each time rx_valid_out fires.
// -----------------------------------------------------------------------------
module tb_spi_peripheral;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         cs     = 1'b1;
  logic         dclk   = 1'b0;
  logic         copi   = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_load = 1'b0;
  logic         chip_data_out;
  logic         tx_ready_out;
  logic [W-1:0] rx_data_out;
  logic         rx_valid_out;
  logic         tx_underrun_out;
  logic         frame_error_out;

  spi_peripheral #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .chip_sel_in     (cs),
    .chip_clk_in     (dclk),
    .chip_data_in    (copi),
    .chip_data_out   (chip_data_out),
    .tx_data_in      (tx_data),
    .tx_load_in      (tx_load),
    .tx_ready_out    (tx_ready_out),
    .rx_data_out     (rx_data_out),
    .rx_valid_out    (rx_valid_out),
    .tx_underrun_out (tx_underrun_out),
    .frame_error_out (frame_error_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard and monitor
  logic [W-1:0] rx_q[$];
  int           got_underrun = 0;
  int           got_ferr     = 0;

  always @(negedge clk_in) begin
    if (rx_valid_out) begin
      if (rx_q.size() == 0) check("rx_unexpected_valid", 32'(rx_valid_out), 32'd0);
      else                  check("rx_word", 32'(rx_data_out), 32'(rx_q.pop_front()));
    end
    if (tx_underrun_out) got_underrun++;
    if (frame_error_out) got_ferr++;
  end

  // Reference model: the TX buffer as a single slot plus expected pulse counts
  logic [W-1:0] mdl_buf  = '0;
  bit           mdl_full = 1'b0;
  int           exp_underrun = 0;
  int           exp_ferr     = 0;
  logic [W-1:0] last_rx = '0;

  logic [W-1:0] fr_copi  [4];
  bit           fr_ld_en [4];
  logic [W-1:0] fr_ld_v  [4];
  logic [W-1:0] exp_tx;
  logic [W-1:0] got_tx;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic load(input logic [W-1:0] v);
    check("tx_ready_before_load", 32'(tx_ready_out), 32'(!mdl_full));
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk_in);
    tx_load = 1'b0;
    if (!mdl_full) begin
      mdl_buf  = v;
      mdl_full = 1'b1;
    end
    check("tx_ready_after_load", 32'(tx_ready_out), 32'(!mdl_full));
  endtask

  task automatic word_start(output logic [W-1:0] e);
    if (mdl_full) begin
      e        = mdl_buf;
      mdl_full = 1'b0;
    end else begin
      e = '0;
      exp_underrun++;
    end
  endtask

  // Clocks nbits bits of one word. CIPO is sampled just before each rising
  // DCLK edge. Every bit except the very first of a frame begins with a DCLK
  // fall. The word ends with DCLK high.
  task automatic xfer(input logic [W-1:0] v, input int nbits, input bit first,
                      input int phase, input bit do_ld, input logic [W-1:0] ld_v,
                      output logic [W-1:0] cipo);
    cipo = '0;
    for (int b = 0; b < nbits; b++) begin
      if (!(first && b == 0)) dclk = 1'b0;
      copi = v[W-1-b];
      cyc(phase);
      if (do_ld && b == 2) load(ld_v);
      cipo[W-1-b] = chip_data_out;
      dclk = 1'b1;
      cyc(phase);
    end
  endtask

  task automatic end_frame(input int phase);
    cs = 1'b1;
    cyc(phase);
    dclk = 1'b0;
    cyc(phase);
  endtask

  task automatic frame(input int nw, input int phase);
    cs = 1'b0;
    for (int w = 0; w < nw; w++) begin
      word_start(exp_tx);
      rx_q.push_back(fr_copi[w]);
      last_rx = fr_copi[w];
      xfer(fr_copi[w], W, (w == 0), phase, fr_ld_en[w], fr_ld_v[w], got_tx);
      check("cipo_word", 32'(got_tx), 32'(exp_tx));
    end
    end_frame(phase);
  endtask

  task automatic check_pulses(input string name);
    cyc(5);
    check({name, "_underrun_count"}, 32'(got_underrun), 32'(exp_underrun));
    check({name, "_frame_err_count"}, 32'(got_ferr), 32'(exp_ferr));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_cipo"},      32'(chip_data_out),   32'd0);
    check({name, "_tx_ready"},  32'(tx_ready_out),    32'd1);
    check({name, "_rx_data"},   32'(rx_data_out),     32'(last_rx));
    check({name, "_rx_valid"},  32'(rx_valid_out),    32'd0);
    check({name, "_underrun"},  32'(tx_underrun_out), 32'd0);
    check({name, "_frame_err"}, 32'(frame_error_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v, t;
    for (int i = 0; i < 4; i++) begin
      fr_copi[i] = '0; fr_ld_en[i] = 1'b0; fr_ld_v[i] = '0;
    end

    // Reset state
    cyc(3);
    check_reset_values("reset");
    rst_in = 1'b1;
    cyc(10);

    // One word with a preloaded response
    load(8'hA5);
    fr_copi[0] = 8'h3C;
    frame(1, 50);
    check("tx_ready_after_frame", 32'(tx_ready_out), 32'(!mdl_full));
    check_pulses("single");

    // No load: underrun, CIPO reads zero
    fr_copi[0] = 8'h6B;
    frame(1, 50);
    check_pulses("underrun");

    // Two words back to back, second response loaded during the first word
    load(8'h81);
    fr_copi[0] = 8'h12; fr_ld_en[0] = 1'b1; fr_ld_v[0] = 8'h7E;
    fr_copi[1] = 8'h34;
    frame(2, 50);
    fr_ld_en[0] = 1'b0;
    check_pulses("two_word");

    // Aborted after five rising edges
    cs = 1'b0;
    word_start(exp_tx);
    xfer(8'hC3, 5, 1'b1, 50, 1'b0, '0, got_tx);
    exp_ferr++;
    end_frame(50);
    check_pulses("abort");
    check("rx_hold_after_abort", 32'(rx_data_out), 32'(last_rx));
    load(8'h55);
    fr_copi[0] = 8'hF0;
    frame(1, 50);
    check_pulses("after_abort");

    // Reset in the middle of a frame, released with CS still low
    load(8'h66);
    cs = 1'b0;
    word_start(exp_tx);
    xfer(8'h99, 3, 1'b1, 50, 1'b0, '0, got_tx);
    rst_in   = 1'b0;
    mdl_full = 1'b0;
    last_rx  = '0;
    cyc(2);
    check_reset_values("mid_reset");
    rst_in = 1'b1;
    cyc(30);
    check_pulses("post_reset_quiet");
    check("post_reset_cipo", 32'(chip_data_out), 32'd0);
    dclk = 1'b0;
    cyc(50);
    cs = 1'b1;
    cyc(50);
    check_pulses("post_reset_idle");
    load(8'h77);
    fr_copi[0] = 8'h5A;
    frame(1, 50);
    check_pulses("post_reset_frame");

    // Random traffic at the fast controller rate, loads sometimes skipped
    for (int i = 0; i < 16; i++) begin
      v = W'($urandom);
      t = W'($urandom);
      if ($urandom_range(0, 3) != 0) load(t);
      fr_copi[0] = v;
      frame(1, 10);
    end
    check_pulses("random");

    // Every expected RX word must have arrived
    for (int i = 0; i < 200 && rx_q.size() != 0; i++) cyc(1);
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
